// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: multi-cycle fetch/decode/execute sequencer for the
// accumulator CPU. Owns PC/IR/AC/DR, drives the shared program/data memory
// and initiates one ALU evaluation per arithmetic instruction through a
// toggle-type activate line.
module alu_control_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        alu_ac,
  output logic [7:0]        alu_dr,
  output logic [OPC_W-1:0]  alu_mode,
  output logic              alu_activate,
  input  logic [7:0]        alu_result,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        ac,
  output logic              halted
);

  localparam int IW = OPC_W + ADDR_W;

  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_NEG = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(7);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_OPERAND,
    S_OPERAND_WAIT,
    S_EXEC,
    S_WB,
    S_STORE,
    S_HALT
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_pc;
  logic [IW-1:0]     r_ir;
  logic [7:0]        r_ac;
  logic [7:0]        r_dr;
  logic [OPC_W-1:0]  r_mode;
  logic              r_act;

  logic [OPC_W-1:0]  w_opc;
  logic [ADDR_W-1:0] w_opnd;

  assign w_opc  = r_ir[IW-1:ADDR_W];
  assign w_opnd = r_ir[ADDR_W-1:0];

  // State register; async reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and memory strobes. Strobes are decoded from the state so a
  // reset pulls an in-flight mem_wr low without waiting for a clock edge.
  always_comb begin
    w_next    = r_state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = r_pc;
        w_next   = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: w_next = S_DECODE;
      S_DECODE: begin
        // NEG operates on AC only, so it skips the operand read.
        if (w_opc == OP_HLT)      w_next = S_HALT;
        else if (w_opc == OP_STA) w_next = S_STORE;
        else if (w_opc == OP_NEG) w_next = S_EXEC;
        else                      w_next = S_OPERAND;
      end
      S_OPERAND: begin
        mem_rd   = 1'b1;
        mem_addr = w_opnd;
        w_next   = S_OPERAND_WAIT;
      end
      S_OPERAND_WAIT: w_next = S_EXEC;
      S_EXEC:         w_next = S_WB;
      S_WB:           w_next = S_FETCH;
      S_STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = w_opnd;
        mem_wdata = r_ac;
        w_next    = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers, each loaded in exactly one state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_ac   <= '0;
      r_dr   <= '0;
      r_mode <= '0;
      r_act  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH_WAIT: begin
          r_ir <= mem_rdata;
          r_pc <= r_pc + 1'b1;  // wraps at the top of memory
        end
        S_DECODE:       r_mode <= w_opc;
        S_OPERAND_WAIT: r_dr   <= mem_rdata;
        S_EXEC:         r_act  <= ~r_act;  // one level change = one request
        S_WB:           r_ac   <= alu_result;
        default: ;
      endcase
    end
  end

  assign alu_ac       = r_ac;
  assign alu_dr       = r_dr;
  assign alu_mode     = r_mode;
  assign alu_activate = r_act;
  assign pc           = r_pc;
  assign ac           = r_ac;
  assign halted       = (r_state == S_HALT);

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench for alu_control_sequencer: directed programs push their
// expected fetch/AC/write/halt events; a negedge monitor pops and compares.
module tb_alu_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] alu_ac, alu_dr;
  logic [2:0] alu_mode;
  logic       alu_activate;
  logic [7:0] alu_result = 8'h00;
  logic [4:0] pc;
  logic [7:0] ac;
  logic       halted;

  alu_control_sequencer #(.ADDR_W(5), .OPC_W(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_mode(alu_mode),
    .alu_activate(alu_activate), .alu_result(alu_result),
    .pc(pc), .ac(ac), .halted(halted)
  );

  always #5 clk = ~clk;

  // memory: synchronous read, data valid the cycle after mem_rd
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // reference ALU evaluated on each activate level change
  always @(alu_activate) begin
    case (alu_mode)
      3'd0: alu_result = alu_ac + alu_dr;
      3'd1: alu_result = {alu_dr[6:0], 1'b0};
      3'd2: alu_result = ~(alu_ac ^ alu_dr);
      3'd3: alu_result = {1'b0, alu_dr[7:1]};
      3'd4: alu_result = alu_dr;
      3'd6: alu_result = ~alu_ac + 8'd1;
      default: alu_result = 8'h00;
    endcase
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  localparam int K_FETCH = 0, K_AC = 1, K_WR = 2, K_HALT = 3;
  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
    int         d;
  } ev_t;
  ev_t sb[$];

  function automatic void push(input int k, input logic [7:0] a, input logic [7:0] b, input int d);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.d = d;
    sb.push_back(e);
  endfunction

  task automatic sb_pop(input int k, input logic [7:0] a, input logic [7:0] b, input int d);
    ev_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL sb_unexpected: got kind=%0d a=%0h b=%0h d=%0d expected no event", k, a, b, d);
    end else begin
      e = sb.pop_front();
      chk($sformatf("sb_kind%0d", e.kind), {8'(k), a, b, 16'(d)},
          {8'(e.kind), e.a, e.b, 16'(e.d)});
    end
  endtask

  // monitor state (written only by the monitor process)
  int         cyc = 0;
  int         last_fetch = 0;
  bit         first = 1'b1;
  logic [7:0] prev_ac = 8'h00;
  logic       prev_act = 1'b0;
  logic       prev_halt = 1'b0;
  int         toggles = 0;
  int         rd_cnt = 0;

  // Monitor: turns observable DUT activity into events for the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      first     = 1'b1;
      prev_ac   = ac;
      prev_act  = alu_activate;
      prev_halt = halted;
    end else begin
      if (alu_activate != prev_act) toggles++;
      if (mem_rd) rd_cnt++;
      if (mem_rd || mem_wr) chk("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'd0);
      if (ac != prev_ac) sb_pop(K_AC, ac, alu_dr, 0);
      if (mem_wr) sb_pop(K_WR, 8'(mem_addr), mem_wdata, 0);
      if (mem_rd && mem_addr == pc) begin
        sb_pop(K_FETCH, 8'(mem_addr), 8'h00, first ? 0 : cyc - last_fetch);
        last_fetch = cyc;
        first = 1'b0;
      end
      if (halted && !prev_halt) sb_pop(K_HALT, 8'(pc), 8'h00, cyc - last_fetch);
      prev_ac   = ac;
      prev_act  = alu_activate;
      prev_halt = halted;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("halt_reached", 64'(halted), 64'd1);
  endtask

  int t0, r0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_rd, mem_wr, mem_addr, mem_wdata, alu_ac, alu_dr,
                          alu_mode, alu_activate, pc, ac, halted}, 64'd0);
    @(negedge clk) rst = 1'b0;

    // ---- LDA then HLT ----
    mem[0] = 8'h85; mem[5] = 8'h3C; mem[1] = 8'hE0;
    push(K_FETCH, 8'h00, 8'h00, 0);
    push(K_AC,    8'h3C, 8'h3C, 0);
    push(K_FETCH, 8'h01, 8'h00, 7);
    push(K_HALT,  8'h02, 8'h00, 3);
    t0 = toggles;
    start_pulse();
    wait_halt(100);
    chk("t1_pc", 64'(pc), 64'd2);
    chk("t1_toggles", 64'(toggles - t0), 64'd1);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // ---- ADD wrap, XNR, NEG, STA, DIV2, ASL; start held high throughout ----
    do_reset();
    clear_mem();
    mem[0] = 8'h94; mem[1] = 8'h15; mem[2] = 8'h96; mem[3] = 8'h57;
    mem[4] = 8'h98; mem[5] = 8'hC0; mem[6] = 8'h99; mem[7] = 8'hBF;
    mem[8] = 8'h7A; mem[9] = 8'h3B; mem[10] = 8'hE0;
    mem[20] = 8'hF0; mem[21] = 8'h20; mem[22] = 8'hAA; mem[23] = 8'h0F;
    mem[24] = 8'h01; mem[25] = 8'h77; mem[26] = 8'h81; mem[27] = 8'hC3;
    push(K_FETCH, 8'd0, 8'h00, 0);  push(K_AC, 8'hF0, 8'hF0, 0);
    push(K_FETCH, 8'd1, 8'h00, 7);  push(K_AC, 8'h10, 8'h20, 0);
    push(K_FETCH, 8'd2, 8'h00, 7);  push(K_AC, 8'hAA, 8'hAA, 0);
    push(K_FETCH, 8'd3, 8'h00, 7);  push(K_AC, 8'h5A, 8'h0F, 0);
    push(K_FETCH, 8'd4, 8'h00, 7);  push(K_AC, 8'h01, 8'h01, 0);
    push(K_FETCH, 8'd5, 8'h00, 7);  push(K_AC, 8'hFF, 8'h01, 0);
    push(K_FETCH, 8'd6, 8'h00, 5);  push(K_AC, 8'h77, 8'h77, 0);
    push(K_FETCH, 8'd7, 8'h00, 7);  push(K_WR, 8'h1F, 8'h77, 0);
    push(K_FETCH, 8'd8, 8'h00, 4);  push(K_AC, 8'h40, 8'h81, 0);
    push(K_FETCH, 8'd9, 8'h00, 7);  push(K_AC, 8'h86, 8'hC3, 0);
    push(K_FETCH, 8'd10, 8'h00, 7); push(K_HALT, 8'd11, 8'h00, 3);
    t0 = toggles; r0 = rd_cnt;
    @(negedge clk) start = 1'b1;
    wait_halt(200);
    start = 1'b0;
    chk("t2_pc", 64'(pc), 64'd11);
    chk("t2_toggles", 64'(toggles - t0), 64'd9);
    chk("t2_rd_cycles", 64'(rd_cnt - r0), 64'd19);
    chk("t2_store_mem", 64'(mem[31]), 64'h77);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // ---- PC wrap with self-modifying store of HLT into address 0 ----
    do_reset();
    clear_mem();
    mem[0] = 8'h83; mem[1] = 8'hC0; mem[2] = 8'hA0; mem[3] = 8'h01; mem[4] = 8'h9E;
    for (int i = 5; i < 30; i++) mem[i] = 8'hA4;
    mem[30] = 8'h81; mem[31] = 8'h3E;
    push(K_FETCH, 8'd0, 8'h00, 0); push(K_AC, 8'h01, 8'h01, 0);
    push(K_FETCH, 8'd1, 8'h00, 7); push(K_AC, 8'hFF, 8'h01, 0);
    push(K_FETCH, 8'd2, 8'h00, 5); push(K_WR, 8'h00, 8'hFF, 0);
    push(K_FETCH, 8'd3, 8'h00, 4); push(K_AC, 8'hBF, 8'hC0, 0);
    push(K_FETCH, 8'd4, 8'h00, 7); push(K_AC, 8'h81, 8'h81, 0);
    push(K_FETCH, 8'd5, 8'h00, 7);
    for (int i = 5; i < 30; i++) begin
      push(K_WR, 8'h04, 8'h81, 0);
      push(K_FETCH, 8'(i + 1), 8'h00, 4);
    end
    push(K_AC, 8'hC0, 8'hC0, 0);
    push(K_FETCH, 8'd31, 8'h00, 7); push(K_AC, 8'h02, 8'h81, 0);
    push(K_FETCH, 8'd0, 8'h00, 7);  push(K_HALT, 8'd1, 8'h00, 3);
    t0 = toggles; r0 = rd_cnt;
    start_pulse();
    wait_halt(600);
    chk("t3_pc", 64'(pc), 64'd1);
    chk("t3_toggles", 64'(toggles - t0), 64'd6);
    chk("t3_rd_cycles", 64'(rd_cnt - r0), 64'd38);
    chk("t3_mem0", 64'(mem[0]), 64'hFF);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // ---- reset while in EXEC, then start needed to resume ----
    do_reset();
    clear_mem();
    mem[0] = 8'h54; mem[20] = 8'h05;
    push(K_FETCH, 8'd0, 8'h00, 0);
    t0 = toggles;
    start_pulse();              // now in FETCH
    repeat (5) @(posedge clk);  // EXEC
    #1;
    chk("t4_pre_dr", 64'(alu_dr), 64'h05);
    rst = 1'b1;
    #1;
    chk("t4_reset_outputs", {mem_rd, mem_wr, mem_addr, mem_wdata, alu_ac, alu_dr,
                             alu_mode, alu_activate, pc, ac, halted}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    r0 = rd_cnt;
    repeat (10) @(negedge clk);
    chk("t4_idle_pc", 64'(pc), 64'd0);
    chk("t4_idle_no_rd", 64'(rd_cnt - r0), 64'd0);
    chk("t4_no_toggle", 64'(toggles - t0), 64'd0);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    mem[0] = 8'hE0;
    push(K_FETCH, 8'd0, 8'h00, 0);
    push(K_HALT, 8'd1, 8'h00, 3);
    start_pulse();
    wait_halt(50);
    chk("t4_resume_sb_empty", 64'(sb.size()), 64'd0);

    // ---- reset while in STORE: write must be dropped ----
    do_reset();
    clear_mem();
    mem[0] = 8'hA9; mem[9] = 8'h55;
    push(K_FETCH, 8'd0, 8'h00, 0);
    start_pulse();              // now in FETCH
    repeat (3) @(posedge clk);  // STORE
    #1;
    chk("t5_wr_pre", {59'd0, mem_wr, 4'd0} | 64'(mem_addr), 64'h19);
    rst = 1'b1;
    #1;
    chk("t5_reset_outputs", {mem_rd, mem_wr, mem_addr, mem_wdata, alu_ac, alu_dr,
                             alu_mode, alu_activate, pc, ac, halted}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("t5_no_write", 64'(mem[9]), 64'h55);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle_pc", 64'(pc), 64'd0);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Multi-cycle fetch/decode/execute sequencer that drives the accumulator ALU (AC, DR, mode, activate) and the shared 8-bit program/data memory of the von Neumann RISC CPU. It owns the PC, IR, AC and DR registers. It issues one ALU operation per instruction and writes the ALU result back to AC, or writes AC to memory for a store. It is the initiator side of the ALU mode/activate interface.

## Interface
- ADDR_W, 5, memory address width; PC and instruction operand width.
- OPC_W, 3, opcode width; equals ALU mode width.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE; begins execution at current PC.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read strobe; mem_rdata valid on the following cycle.
- mem_wr  out  1  write strobe; memory captures mem_wdata at mem_addr on this edge.
- mem_wdata  out  8  store data (AC).
- mem_rdata  in  8  read data.
- alu_ac  out  8  continuous copy of AC register.
- alu_dr  out  8  continuous copy of DR register.
- alu_mode  out  OPC_W  registered opcode (IR[7:5]).
- alu_activate  out  1  toggle-type activate: each change of level requests one ALU evaluation.
- alu_result  in  8  ALU result, valid by the cycle after a toggle.
- pc  out  ADDR_W  current PC.
- ac  out  8  current AC.
- halted  out  1  high in HALT state.

## Operation
- Instruction word: IR[7:5] opcode, IR[4:0] operand address.
- Opcodes: 000 ADD (AC+M), 001 ASL (M<<1), 010 XNR (~(AC^M)), 011 DIV2 (M>>1), 100 LDA (M), 101 STA (M<=AC), 110 NEG (~AC+1), 111 HLT.
- All opcodes except STA and HLT use the ALU. The result is always written to AC, 8-bit, and carries are discarded.
- States:
  - IDLE: go to FETCH when start=1.
  - FETCH: mem_rd=1, mem_addr=PC.
  - FETCH_WAIT: IR<=mem_rdata, PC<=PC+1 (wraps 31->0).
  - DECODE: alu_mode<=IR[7:5]. HLT->HALT; STA->STORE; NEG->EXEC; otherwise ->OPERAND.
  - OPERAND: mem_rd=1, mem_addr=IR[4:0].
  - OPERAND_WAIT: DR<=mem_rdata.
  - EXEC: alu_activate<=~alu_activate.
  - WB: AC<=alu_result, then FETCH.
  - STORE: mem_wr=1, mem_addr=IR[4:0], mem_wdata=AC, then FETCH.
  - HALT: terminal; exited only by rst.
- mem_rd and mem_wr are never high together. Both are low in IDLE, DECODE, EXEC, WB and HALT.
- start is ignored outside IDLE.
- Self-modifying store to the address of the next instruction is legal; the fetch reads the new value.

## Timing
- Reset values: state=IDLE, PC=0, IR=0, AC=0, DR=0, alu_mode=0, alu_activate=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, halted=0.
- Reset mid-instruction aborts immediately. No pending write is issued; an in-flight mem_wr is deasserted asynchronously.
- Cycles per instruction, counted from FETCH entry to the next FETCH entry:
  - ADD/ASL/XNR/DIV2/LDA: 7.
  - NEG: 5.
  - STA: 4.
  - HLT reaches HALT 3 cycles after FETCH.
- IDLE->FETCH takes 1 cycle after start is sampled high.
- Exactly one alu_activate toggle per ALU instruction. No toggle occurs for STA, HLT, or in reset.
- alu_result is sampled in WB, one full cycle after the toggle edge.
- DR keeps its last loaded value across NEG and STA.

## Test plan
- Reset then start; mem[0]=0x85 (LDA 5), mem[5]=0x3C, mem[1]=0xE0 (HLT) -> AC=0x3C after 7 cycles; halted=1 three cycles later; PC=2; exactly one activate toggle.
- ADD wrap: AC=0xF0, ADD of mem=0x20 -> AC=0x10. XNR with AC=0xAA, M=0x0F -> AC=0x5A.
- NEG with AC=0x01 -> AC=0xFF in 5 cycles. No mem_rd in the OPERAND slot; DR unchanged.
- STA 0x1F with AC=0x77 -> single mem_wr cycle, addr=0x1F, wdata=0x77, 4 cycles total. AC unchanged; no activate toggle.
- PC wrap: instruction at address 31 (ASL of M=0x81 -> AC=0x02) -> next fetch at address 0.
- Assert rst in EXEC and in STORE -> all outputs return to reset values at once, no write occurs, and start is required to resume.
